// File: rtl/sram_responder_if.sv
// Control/address pins of the asynchronous-SRAM-style bus seen by sram_responder.
// The data bus stays a plain inout port on the responder so tristate resolution stays simple.
interface sram_responder_if;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_LB_N;
    logic        SRAM_UB_N;

    modport master (
        output SRAM_ADDR, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N
    );

    modport slave (
        input SRAM_ADDR, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N
    );
endinterface

// File: rtl/sram_responder.sv
// Synchronous 16-bit SRAM model with byte lanes, one-cycle read latency and cycle counters.
// Optional macro SRAM_RESPONDER_PROTOCOL_CHECK_EN enables the sticky protocol-error flag.
module sram_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    sram_responder_if.slave   bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [15:0]       o_WR_CNT,
    output logic [15:0]       o_RD_CNT,
    output logic              o_ERR
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem [DEPTH];
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] word_addr;
    logic              selected;
    logic              wr_cyc;
    logic              rd_cyc;
    logic              lo_drv;
    logic              hi_drv;

    // Upper address bits are dropped so addresses alias modulo the depth.
    assign word_addr = bus.SRAM_ADDR[ADDR_W-1:0];
    assign selected  = ~bus.SRAM_CE_N;
    // A write wins over a simultaneous OE_N assertion.
    assign wr_cyc    = selected & ~bus.SRAM_WE_N;
    assign rd_cyc    = selected &  bus.SRAM_WE_N & ~bus.SRAM_OE_N;

    // Memory has no reset: contents survive reset and are undefined until written.
    always_ff @(posedge i_clk) begin
        if (wr_cyc) begin
            if (!bus.SRAM_LB_N) mem[word_addr][7:0]  <= SRAM_DQ[7:0];
            if (!bus.SRAM_UB_N) mem[word_addr][15:8] <= SRAM_DQ[15:8];
        end
        if (rd_cyc) rd_data <= mem[word_addr];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_valid <= 1'b0;
            o_WR_CNT <= 16'd0;
            o_RD_CNT <= 16'd0;
        end else begin
            rd_valid <= rd_cyc;
            if (wr_cyc && o_WR_CNT != 16'hFFFF) o_WR_CNT <= o_WR_CNT + 16'd1;
            if (rd_cyc && o_RD_CNT != 16'hFFFF) o_RD_CNT <= o_RD_CNT + 16'd1;
        end
    end

    // Lane enables follow the live pins so the bus releases as soon as the master lets go.
    assign lo_drv = rd_valid & selected & bus.SRAM_WE_N & ~bus.SRAM_OE_N & ~bus.SRAM_LB_N;
    assign hi_drv = rd_valid & selected & bus.SRAM_WE_N & ~bus.SRAM_OE_N & ~bus.SRAM_UB_N;

    assign SRAM_DQ[7:0]  = lo_drv ? rd_data[7:0]  : 8'hzz;
    assign SRAM_DQ[15:8] = hi_drv ? rd_data[15:8] : 8'hzz;

`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
    logic proto_bad;

    assign proto_bad = selected & (
                           (~bus.SRAM_WE_N & ~bus.SRAM_OE_N) |
                           (|(bus.SRAM_ADDR >> ADDR_W)) |
                           (bus.SRAM_LB_N & bus.SRAM_UB_N));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)       o_ERR <= 1'b0;
        else if (proto_bad) o_ERR <= 1'b1;
    end
`else
    logic unused_addr_hi;

    assign unused_addr_hi = |(bus.SRAM_ADDR >> ADDR_W);
    assign o_ERR          = 1'b0;
`endif

endmodule
